fc_layer_sequencer: RTL and testbench
=====================================

Name: fc_layer_sequencer

Overview:
- Sequences the two fully-connected layers over the three-memory FC datapath (MEM1: input cells + L1 weights, MEM2: hidden cells + L2 weights, MEM3: output cells).
- Issues every memory read and write, selects the active memory and performs the signed fixed-point MAC, activation and saturation.
- Drives the memory-select demux/mux pair through mem_sel and reports per-layer completion flags.

Parameters:
- FRT_CELL, 14, number of input cells (layer-1 fan-in)
- MID_CELL, 10, number of hidden cells (layer-1 outputs, layer-2 fan-in)
- BCK_CELL, 5, number of output cells
- FRAC_BITS, 8, fractional bits of the Q-format data (default Q8.8)
- ACC_W, 40, accumulator width in bits

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin a full L1+L2 pass; sampled only in IDLE
- rd_data  in  16  signed read data from the memory selected by mem_sel; one-cycle read latency
- mem_sel  out  2  0=MEM1, 1=MEM2, 2=MEM3; 3 is never driven
- we  out  1  write enable to the selected memory
- addr  out  16  memory address
- wdata  out  16  write data
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse when the pass completes
- fc1_end  out  1  level; layer 1 complete; cleared by the next accepted start
- fc2_end  out  1  level; layer 2 complete; cleared by the next accepted start

Behaviour:
- Reset (async, immediate): state=IDLE; mem_sel, we, addr, wdata, busy, done, fc1_end, fc2_end all 0; accumulator, counters and operand registers cleared. Memory contents are not touched.
- Memory layout for a layer with fan-in N and M outputs:
  - cell i at address i
  - weight (output j, input i) at address N + j*N + i
  - layer output j is written to address j of the next memory
- States: IDLE, RD_X, RD_W, ACC, WR, DONE. Counters: layer L (1/2), output j, input i.
- IDLE: start=1 → L=1, j=0, i=0, acc=0, clear fc1_end/fc2_end, go to RD_X. start is ignored in every other state.
- RD_X:
  - mem_sel = read memory (L1→0, L2→1), addr=i, we=0 → RD_W.
- RD_W:
  - capture x=rd_data
  - addr = N + j*N + i → ACC
- ACC:
  - capture w=rd_data
  - acc += sign-extended x*w (full 32-bit product)
  - if i==N-1, go to WR; else i++ and go to RD_X
- WR:
  - mem_sel = write memory (L1→1, L2→2), addr=j, we=1
  - wdata = act(sat16(acc >>> FRAC_BITS)), where sat16 clamps to [-32768, 32767]
  - act = ReLU (negative→0) for L1; identity for L2
  - Then acc=0, i=0:
    - j<M-1 → j++, go to RD_X
    - L=1 and j==MID_CELL-1 → fc1_end=1, L=2, j=0, go to RD_X
    - L=2 and j==BCK_CELL-1 → fc2_end=1, go to DONE
- DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Outputs are registered. busy is high from the cycle after start is accepted through the final WR cycle.
- we is high only in WR cycles; addr/mem_sel hold their last values in IDLE.
- Latency:
  - per output: 3N+1 cycles
  - default pass: 10*(3*14+1) + 5*(3*10+1) = 585 busy cycles
  - done in cycle 586 after the start edge
- mem_sel changes only on state transitions. fc1_end/fc2_end are set in the same edge as the final write of their layer, matching the demux switch point.
- Simultaneous reset and start: reset wins.
- Reset mid-pass: abort immediately, no further writes. Partially written results remain in memory.

Test Plan:
1. Reset values: assert reset with start=1 → all outputs 0 and state IDLE. Deassert and hold start=0 for 20 cycles → no we pulses.
2. Saturation path: MEM1 cells and weights all 0x0100 (1.0) →
   - MEM2[0..9] written with 0x0E00
   - MEM3[0..4] written with 0x7FFF (140.0 saturates)
   - exactly 15 we pulses
3. ReLU path: L1 weights all 0xFF00 (-1.0), cells 0x0100 → MEM2 cells = 0x0000 and MEM3 cells = 0x0000.
4. Timing: default params → first write at cycle 43 after the start edge (mem_sel=1, addr=0), fc1_end rises at cycle 430, done pulses at cycle 586 for one cycle, busy falls at the same edge.
5. Start pulsed at cycles 5 and 300 of a pass → ignored, with identical results and timing. Assert reset at cycle 500 (layer 2) → all outputs 0 at once. A restart then gives the same results as scenario 2.
6. Small config FRT=2, MID=2, BCK=1:
   - cells 0x0200 and 0x0100; weights 0x0100, 0x0080, 0xFF00, 0x0100
   - L1 outputs 0x0280 and 0x0000 (-1.0 clamped by ReLU)
   - L2 weights 0x0100, 0x0100 → MEM3[0] = 0x0280

Source files
------------

// File: rtl/fc_layer_sequencer.sv
// Two-layer fully-connected sequencer: walks MEM1 -> MEM2 -> MEM3, doing the
// signed Q-format MAC, saturation and ReLU, and issuing every memory access.
module fc_layer_sequencer #(
   parameter int FRT_CELL  = 14,
   parameter int MID_CELL  = 10,
   parameter int BCK_CELL  = 5,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] rd_data,
   output logic [1:0]  mem_sel,
   output logic        we,
   output logic [15:0] addr,
   output logic [15:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        fc1_end,
   output logic        fc2_end
);

   localparam logic [15:0] P_FRT = 16'(FRT_CELL);
   localparam logic [15:0] P_MID = 16'(MID_CELL);
   localparam logic [15:0] P_BCK = 16'(BCK_CELL);

   typedef enum logic [2:0] {S_IDLE, S_RD_X, S_RD_W, S_ACC, S_WR, S_DONE} state_t;

   state_t                   r_state, w_state_n;
   logic                     r_layer, w_layer_n;   // 0 = layer 1, 1 = layer 2
   logic [15:0]              r_j, w_j_n, r_i, w_i_n;
   logic signed [ACC_W-1:0]  r_acc, w_acc_n;
   logic signed [15:0]       r_x, w_x_n;
   logic [1:0]               r_mem_sel, w_mem_sel_n;
   logic                     r_we, w_we_n, r_busy, w_busy_n, r_done, w_done_n;
   logic                     r_fc1, w_fc1_n, r_fc2, w_fc2_n;
   logic [15:0]              r_addr, w_addr_n, r_wdata, w_wdata_n;

   logic [15:0]              w_n, w_m;
   logic signed [31:0]       w_prod;
   logic signed [ACC_W-1:0]  w_acc_sum, w_shift;
   logic [ACC_W-16:0]        w_hi;
   logic [15:0]              w_sat, w_act;

   assign w_n       = r_layer ? P_MID : P_FRT;
   assign w_m       = r_layer ? P_BCK : P_MID;
   assign w_prod    = r_x * $signed(rd_data);
   assign w_acc_sum = r_acc + {{(ACC_W-32){w_prod[31]}}, w_prod};
   assign w_shift   = w_acc_sum >>> FRAC_BITS;
   assign w_hi      = w_shift[ACC_W-1:15];

   // Result is written in the cycle after the last product, so it is formed
   // from the accumulator value that includes that product.
   always_comb begin
      if (w_hi == '0 || w_hi == '1) w_sat = w_shift[15:0];
      else                          w_sat = w_shift[ACC_W-1] ? 16'h8000 : 16'h7FFF;
      w_act = (!r_layer && w_sat[15]) ? 16'h0000 : w_sat;
   end

   always_comb begin
      w_state_n   = r_state;
      w_layer_n   = r_layer;
      w_j_n       = r_j;
      w_i_n       = r_i;
      w_acc_n     = r_acc;
      w_x_n       = r_x;
      w_mem_sel_n = r_mem_sel;
      w_addr_n    = r_addr;
      w_wdata_n   = r_wdata;
      w_busy_n    = r_busy;
      w_fc1_n     = r_fc1;
      w_fc2_n     = r_fc2;
      w_we_n      = 1'b0;
      w_done_n    = 1'b0;
      case (r_state)
         S_IDLE: if (start) begin
            w_state_n   = S_RD_X;
            w_layer_n   = 1'b0;
            w_j_n       = '0;
            w_i_n       = '0;
            w_acc_n     = '0;
            w_fc1_n     = 1'b0;
            w_fc2_n     = 1'b0;
            w_busy_n    = 1'b1;
            w_mem_sel_n = 2'd0;
            w_addr_n    = '0;
         end
         S_RD_X: begin
            w_state_n = S_RD_W;
            w_addr_n  = w_n * (r_j + 16'd1) + r_i;
         end
         S_RD_W: begin
            w_state_n = S_ACC;
            w_x_n     = $signed(rd_data);
         end
         S_ACC: begin
            w_acc_n = w_acc_sum;
            if (r_i == w_n - 16'd1) begin
               w_state_n   = S_WR;
               w_we_n      = 1'b1;
               w_mem_sel_n = r_layer ? 2'd2 : 2'd1;
               w_addr_n    = r_j;
               w_wdata_n   = w_act;
               if (!r_layer && r_j == P_MID - 16'd1) w_fc1_n = 1'b1;
               if (r_layer && r_j == P_BCK - 16'd1)  w_fc2_n = 1'b1;
            end else begin
               w_state_n = S_RD_X;
               w_i_n     = r_i + 16'd1;
               w_addr_n  = r_i + 16'd1;
            end
         end
         S_WR: begin
            w_acc_n = '0;
            w_i_n   = '0;
            if (r_j < w_m - 16'd1) begin
               w_state_n   = S_RD_X;
               w_j_n       = r_j + 16'd1;
               w_mem_sel_n = r_layer ? 2'd1 : 2'd0;
               w_addr_n    = '0;
            end else if (!r_layer) begin
               w_state_n   = S_RD_X;
               w_layer_n   = 1'b1;
               w_j_n       = '0;
               w_mem_sel_n = 2'd1;
               w_addr_n    = '0;
            end else begin
               w_state_n = S_DONE;
               w_busy_n  = 1'b0;
               w_done_n  = 1'b1;
            end
         end
         S_DONE:  w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_layer   <= 1'b0;
         r_j       <= '0;
         r_i       <= '0;
         r_acc     <= '0;
         r_x       <= '0;
         r_mem_sel <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_we      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_fc1     <= 1'b0;
         r_fc2     <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_layer   <= w_layer_n;
         r_j       <= w_j_n;
         r_i       <= w_i_n;
         r_acc     <= w_acc_n;
         r_x       <= w_x_n;
         r_mem_sel <= w_mem_sel_n;
         r_addr    <= w_addr_n;
         r_wdata   <= w_wdata_n;
         r_we      <= w_we_n;
         r_busy    <= w_busy_n;
         r_done    <= w_done_n;
         r_fc1     <= w_fc1_n;
         r_fc2     <= w_fc2_n;
      end
   end

   assign mem_sel = r_mem_sel;
   assign we      = r_we;
   assign addr    = r_addr;
   assign wdata   = r_wdata;
   assign busy    = r_busy;
   assign done    = r_done;
   assign fc1_end = r_fc1;
   assign fc2_end = r_fc2;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: memory models, a plain-arithmetic reference
// of both layers, and cycle-accurate timing probes.
module tb_fc_layer_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0, start2 = 1'b0;
   logic [15:0] rd_data = '0, rd_data2 = '0;
   logic [1:0]  mem_sel, mem_sel2;
   logic        we, we2, busy, busy2, done, done2;
   logic        fc1_end, fc2_end, fc1_end2, fc2_end2;
   logic [15:0] addr, wdata, addr2, wdata2;

   int checks = 0;
   int failures = 0;

   logic [15:0] mem  [0:3][0:255];
   logic [15:0] smem [0:3][0:15];
   logic [15:0] exp_h [0:9];
   logic [15:0] exp_o [0:4];

   int first_wr_cyc, fc1_cyc, done_cyc, busy_fall, we_cnt, done_cnt;
   logic [1:0]  first_wr_sel;
   logic [15:0] first_wr_addr;
   logic        busy_at1;

   always #5 clk = ~clk;

   fc_layer_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .rd_data(rd_data),
      .mem_sel(mem_sel), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .fc1_end(fc1_end), .fc2_end(fc2_end));

   fc_layer_sequencer #(.FRT_CELL(2), .MID_CELL(2), .BCK_CELL(1)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .rd_data(rd_data2),
      .mem_sel(mem_sel2), .we(we2), .addr(addr2), .wdata(wdata2),
      .busy(busy2), .done(done2), .fc1_end(fc1_end2), .fc2_end(fc2_end2));

   // One-cycle-latency synchronous memories behind the mem_sel mux/demux
   always @(posedge clk) begin
      rd_data <= mem[mem_sel][addr[7:0]];
      if (we) mem[mem_sel][addr[7:0]] = wdata;
   end
   always @(posedge clk) begin
      rd_data2 <= smem[mem_sel2][addr2[3:0]];
      if (we2) smem[mem_sel2][addr2[3:0]] = wdata2;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] sat_act(input longint acc, input bit relu);
      longint s;
      s = acc >>> 8;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      return s[15:0];
   endfunction

   task automatic model();
      longint acc;
      for (int j = 0; j < 10; j++) begin
         acc = 0;
         for (int i = 0; i < 14; i++)
            acc += longint'($signed(mem[0][i])) * longint'($signed(mem[0][14 + j*14 + i]));
         exp_h[j] = sat_act(acc, 1'b1);
      end
      for (int j = 0; j < 5; j++) begin
         acc = 0;
         for (int i = 0; i < 10; i++)
            acc += longint'($signed(exp_h[i])) * longint'($signed(mem[1][10 + j*10 + i]));
         exp_o[j] = sat_act(acc, 1'b0);
      end
   endtask

   // mode 0: all 1.0; mode 1: L1 weights -1.0; mode 2: random in [-2.0, 2.0)
   task automatic load(input int mode);
      for (int m = 0; m < 4; m++)
         for (int a = 0; a < 256; a++) mem[m][a] = 16'hDEAD;
      for (int a = 0; a < 154; a++)
         mem[0][a] = (mode == 2) ? 16'(int'($urandom_range(0, 1023)) - 512)
                   : (mode == 1 && a >= 14) ? 16'hFF00 : 16'h0100;
      for (int a = 10; a < 60; a++)
         mem[1][a] = (mode == 2) ? 16'(int'($urandom_range(0, 1023)) - 512) : 16'h0100;
      model();
   endtask

   task automatic run_pass(input bit extra_starts, input int abort_at);
      first_wr_cyc = 0; fc1_cyc = 0; done_cyc = 0; busy_fall = 0;
      we_cnt = 0; done_cnt = 0; busy_at1 = 1'b0;
      first_wr_sel = '0; first_wr_addr = '0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int cyc = 1; cyc <= 1200; cyc++) begin
         if (cyc == 1) busy_at1 = busy;
         if (we) begin
            we_cnt++;
            if (first_wr_cyc == 0) begin
               first_wr_cyc = cyc; first_wr_sel = mem_sel; first_wr_addr = addr;
            end
         end
         if (fc1_end && fc1_cyc == 0) fc1_cyc = cyc;
         if (done) begin done_cnt++; if (done_cyc == 0) done_cyc = cyc; end
         if (!busy && busy_fall == 0) busy_fall = cyc;
         if (cyc == abort_at) begin
            chk("abort_fc1_before", 64'(fc1_end), 64'd1);
            reset = 1'b1; #1;
            chk("abort_outs_zero", 64'({mem_sel, we, addr, wdata, busy, done, fc1_end, fc2_end}), 64'd0);
            we_cnt = 0;
            repeat (5) begin @(posedge clk); #1; if (we) we_cnt++; end
            chk("abort_no_writes", 64'(we_cnt), 64'd0);
            @(negedge clk); reset = 1'b0;
            return;
         end
         if (done_cyc != 0 && cyc >= done_cyc + 2) break;
         if (extra_starts && (cyc == 5 || cyc == 300)) start = 1'b1;
         @(posedge clk); #1; start = 1'b0;
      end
   endtask

   task automatic check_pass(input string tag);
      for (int j = 0; j < 10; j++) chk({tag, "_hid"}, 64'(mem[1][j]), 64'(exp_h[j]));
      for (int j = 0; j < 5; j++)  chk({tag, "_out"}, 64'(mem[2][j]), 64'(exp_o[j]));
      chk({tag, "_we_cnt"},    64'(we_cnt), 64'd15);
      chk({tag, "_first_wr"},  64'(first_wr_cyc), 64'd43);
      chk({tag, "_first_sel"}, 64'(first_wr_sel), 64'd1);
      chk({tag, "_first_adr"}, 64'(first_wr_addr), 64'd0);
      chk({tag, "_fc1_cyc"},   64'(fc1_cyc), 64'd430);
      chk({tag, "_done_cyc"},  64'(done_cyc), 64'd586);
      chk({tag, "_done_cnt"},  64'(done_cnt), 64'd1);
      chk({tag, "_busy_fall"}, 64'(busy_fall), 64'd586);
      chk({tag, "_busy_1"},    64'(busy_at1), 64'd1);
      chk({tag, "_ends"},      64'({fc1_end, fc2_end, busy}), 64'b110);
   endtask

   initial begin
      int cnt, dcyc;
      // Reset held with start asserted: reset wins
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", 64'({mem_sel, we, addr, wdata, busy, done, fc1_end, fc2_end}), 64'd0);
      @(negedge clk); start = 1'b0; reset = 1'b0;
      cnt = 0;
      repeat (20) begin @(posedge clk); #1; if (we || busy) cnt++; end
      chk("idle_no_activity", 64'(cnt), 64'd0);

      load(0);
      chk("model_sat_h", 64'(exp_h[3]), 64'h0E00);
      chk("model_sat_o", 64'(exp_o[2]), 64'h7FFF);
      run_pass(1'b0, 0);
      check_pass("sat");
      chk("sat_h0_lit", 64'(mem[1][0]), 64'h0E00);
      chk("sat_o4_lit", 64'(mem[2][4]), 64'h7FFF);

      load(1);
      run_pass(1'b0, 0);
      check_pass("relu");

      for (int r = 0; r < 2; r++) begin
         load(2);
         run_pass(r == 1, 0);
         check_pass(r == 1 ? "rnd_starts" : "rnd");
      end

      load(0);
      run_pass(1'b0, 500);
      chk("abort_partial_o0", 64'(mem[2][0]), 64'h7FFF);
      chk("abort_untouched_o4", 64'(mem[2][4]), 64'hDEAD);
      load(0);
      run_pass(1'b0, 0);
      check_pass("restart");

      // Small configuration on the second instance
      for (int m = 0; m < 4; m++)
         for (int a = 0; a < 16; a++) smem[m][a] = 16'hDEAD;
      smem[0][0] = 16'h0200; smem[0][1] = 16'h0100;
      smem[0][2] = 16'h0100; smem[0][3] = 16'h0080;
      smem[0][4] = 16'hFF00; smem[0][5] = 16'h0100;
      smem[1][2] = 16'h0100; smem[1][3] = 16'h0100;
      @(negedge clk); start2 = 1'b1;
      @(posedge clk); #1; start2 = 1'b0;
      dcyc = 0;
      for (int cyc = 1; cyc <= 200 && dcyc == 0; cyc++) begin
         if (done2) dcyc = cyc;
         else begin @(posedge clk); #1; end
      end
      chk("small_done_cyc", 64'(dcyc), 64'd22);
      chk("small_h0", 64'(smem[1][0]), 64'h0280);
      chk("small_h1", 64'(smem[1][1]), 64'h0000);
      chk("small_o0", 64'(smem[2][0]), 64'h0280);
      chk("small_ends", 64'({fc1_end2, fc2_end2}), 64'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
